// File: rtl/expr_checker.sv
// expr_checker
//
// Streaming validator for arithmetic expressions of the form
//   operand (op operand)*
// where an operand is a decimal number of 1..MAX_DIGITS digits, or, when
// parentheses are enabled, a parenthesised sub-expression.
// Spaces are ignored between tokens. A space cannot appear inside a number.
// One ASCII character is consumed per cycle in which in_valid is high.
//
// Configuration macro:
//   EXPR_PAREN_EN  defined   : '(' and ')' nest up to MAX_DEPTH levels
//                  undefined : '(' and ')' are illegal; depth is tied to 0
//
// Ports:
//   clk       rising-edge clock
//   clr       asynchronous active-high reset
//   in_valid  'in' carries a character this cycle
//   in        ASCII character
//   out       characters accepted so far form a complete, balanced expression
//   err       sticky error flag (held until clr)
//   depth     current open-parenthesis count
//   len       characters consumed; saturates; freezes once an error is seen
module expr_checker #(
  parameter  int MAX_DIGITS = 4,
  parameter  int MAX_DEPTH  = 7,
  parameter  int LEN_W      = 8,
  localparam int DW         = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic             out,
  output logic             err,
  output logic [DW-1:0]    depth,
  output logic [LEN_W-1:0] len
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [2:0] {
    S_START = 3'd0,  // expecting an operand
    S_NUM   = 3'd1,  // inside a number
    S_END   = 3'd2,  // operand complete, further digits not allowed
    S_OPR   = 3'd3,  // just after an operator
    S_ERR   = 3'd4   // absorbing error state
  } state_t;

  typedef enum logic [2:0] {
    C_DIG,
    C_OP,
    C_SP,
    C_LP,
    C_RP,
    C_BAD
  } cls_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              out_q, out_d;
  cls_t              cls;

  // Character classification. Without parenthesis support the bracket
  // characters fall through to the illegal class.
  always_comb begin
    cls = C_BAD;
    if (in >= 8'h30 && in <= 8'h39) begin
      cls = C_DIG;
    end else begin
      case (in)
        8'h2B, 8'h2D, 8'h2A, 8'h2F: cls = C_OP;
        8'h20:                      cls = C_SP;
`ifdef EXPR_PAREN_EN
        8'h28:                      cls = C_LP;
        8'h29:                      cls = C_RP;
`endif
        default:                    cls = C_BAD;
      endcase
    end
  end

  // Next-state logic. Overflow/underflow checks come first so that the
  // digit count and depth are left untouched by the offending character.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    depth_d = depth_q;
    len_d   = len_q;

    if (in_valid && state_q != S_ERR) begin
      // The offending character itself is still counted, so after an
      // error len is the offending index + 1.
      if (len_q != {LEN_W{1'b1}}) begin
        len_d = len_q + 1'b1;
      end

      case (state_q)
        S_START, S_OPR: begin
          case (cls)
            C_DIG: begin
              state_d = S_NUM;
              cnt_d   = CW'(1);
            end
            C_LP: begin
              if (depth_q == DW'(MAX_DEPTH)) begin
                state_d = S_ERR;
              end else begin
                state_d = S_START;
                depth_d = depth_q + 1'b1;
              end
            end
            C_SP:    state_d = state_q;
            default: state_d = S_ERR;
          endcase
        end

        S_NUM: begin
          case (cls)
            C_DIG: begin
              if (cnt_q == CW'(MAX_DIGITS)) begin
                state_d = S_ERR;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
            C_OP: state_d = S_OPR;
            C_SP: state_d = S_END;
            C_RP: begin
              if (depth_q == '0) begin
                state_d = S_ERR;
              end else begin
                state_d = S_END;
                depth_d = depth_q - 1'b1;
              end
            end
            default: state_d = S_ERR;
          endcase
        end

        S_END: begin
          case (cls)
            C_OP: state_d = S_OPR;
            C_SP: state_d = S_END;
            C_RP: begin
              if (depth_q == '0) begin
                state_d = S_ERR;
              end else begin
                depth_d = depth_q - 1'b1;
              end
            end
            default: state_d = S_ERR;
          endcase
        end

        default: state_d = S_ERR;
      endcase
    end

    // Registered completion flag derived from the upcoming state.
    out_d = (state_d == S_NUM || state_d == S_END) && (depth_d == '0);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_START;
      cnt_q   <= '0;
      len_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      out_q   <= out_d;
    end
  end

`ifdef EXPR_PAREN_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end
`else
  // No bracket characters are ever legal, so nesting is always zero.
  assign depth_q = '0;
`endif

  assign out   = out_q;
  assign err   = (state_q == S_ERR);
  assign depth = depth_q;
  assign len   = len_q;

endmodule

// File: tb/tb_expr_checker.sv
module tb_expr_checker;

  localparam int MAX_DIGITS = 4;
  localparam int MAX_DEPTH  = 7;
  localparam int LEN_W      = 8;
  localparam int DW         = $clog2(MAX_DEPTH + 1);
  localparam int LEN_MAX    = (1 << LEN_W) - 1;

  logic             clk = 1'b0;
  logic             clr;
  logic             in_valid;
  logic [7:0]       in_ch;
  logic             out;
  logic             err;
  logic [DW-1:0]    depth;
  logic [LEN_W-1:0] len;

  int tests = 0;
  int fails = 0;

  expr_checker #(
    .MAX_DIGITS(MAX_DIGITS),
    .MAX_DEPTH (MAX_DEPTH),
    .LEN_W     (LEN_W)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .in_valid(in_valid),
    .in      (in_ch),
    .out     (out),
    .err     (err),
    .depth   (depth),
    .len     (len)
  );

  always #5 clk = ~clk;

  // Reference model: token-level view of the grammar.
  // m_last: kind of the last non-space token (0 none, 1 digit, 2 op, 3 '(', 4 ')')
  // m_gap : a space has been seen since the last digit
  int m_last, m_run, m_depth, m_len;
  bit m_gap, m_err;

  task automatic model_reset();
    m_last = 0; m_run = 0; m_depth = 0; m_len = 0; m_gap = 0; m_err = 0;
  endtask

  function automatic bit m_out();
    return !m_err && (m_last == 1 || m_last == 4) && m_depth == 0;
  endfunction

  task automatic model_step(input byte ch);
    bit ok;
    bit paren;
    if (m_err) return;
    m_len = (m_len < LEN_MAX) ? m_len + 1 : LEN_MAX;
`ifdef EXPR_PAREN_EN
    paren = 1;
`else
    paren = 0;
`endif
    ok = 0;
    if (ch >= "0" && ch <= "9") begin
      if (m_last == 1 && !m_gap) begin
        ok = (m_run < MAX_DIGITS);
        if (ok) m_run++;
      end else begin
        ok = (m_last == 0 || m_last == 2 || m_last == 3);
        if (ok) m_run = 1;
      end
      if (ok) begin m_last = 1; m_gap = 0; end
    end else if (ch == "+" || ch == "-" || ch == "*" || ch == "/") begin
      ok = (m_last == 1 || m_last == 4);
      if (ok) begin m_last = 2; m_gap = 0; end
    end else if (ch == " ") begin
      ok = 1;
      m_gap = 1;
    end else if (paren && ch == "(") begin
      ok = (m_last == 0 || m_last == 2 || m_last == 3) && m_depth < MAX_DEPTH;
      if (ok) begin m_last = 3; m_depth++; end
    end else if (paren && ch == ")") begin
      ok = (m_last == 1 || m_last == 4) && m_depth > 0;
      if (ok) begin m_last = 4; m_depth--; end
    end
    if (!ok) m_err = 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out"},   32'(out),   32'(m_out()));
    check({tag, ".err"},   32'(err),   32'(m_err));
    check({tag, ".depth"}, 32'(depth), 32'(m_depth));
    check({tag, ".len"},   32'(len),   32'(m_len));
  endtask

  // One cycle: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic send(input byte ch, input bit v);
    @(negedge clk);
    in_ch    = ch;
    in_valid = v;
    @(posedge clk);
    #1;
    if (v) model_step(ch);
    check_model("step");
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i], 1'b1);
  endtask

  // Asynchronous clear asserted mid-cycle; outputs must drop before any edge.
  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    #1;
    check("clr.out",   32'(out),   0);
    check("clr.err",   32'(err),   0);
    check("clr.depth", 32'(depth), 0);
    check("clr.len",   32'(len),   0);
    model_reset();
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    string s;
    string alpha;
    int    exp_out[7];
    int    exp_dep[7];
    int    exp_po[7];

    clr = 1'b1; in_valid = 1'b0; in_ch = 8'h00;
    model_reset();
    #12;
    check("reset.out",   32'(out),   0);
    check("reset.err",   32'(err),   0);
    check("reset.depth", 32'(depth), 0);
    check("reset.len",   32'(len),   0);
    @(negedge clk);
    clr = 1'b0;

    // Multi-digit operands and several operators
    s = "12+3*45";
    exp_out = '{1, 1, 0, 1, 0, 1, 1};
    for (int i = 0; i < s.len(); i++) begin
      send(s[i], 1'b1);
      check("expr1.out_seq", 32'(out), 32'(exp_out[i]));
    end
    check("expr1.len", 32'(len), 7);
    check("expr1.err", 32'(err), 0);

    // Nested parentheses
    do_clr();
    s = "(1+(2))";
`ifdef EXPR_PAREN_EN
    exp_dep = '{1, 1, 1, 2, 2, 1, 0};
    exp_po  = '{0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < s.len(); i++) begin
      send(s[i], 1'b1);
      check("paren.depth_seq", 32'(depth), 32'(exp_dep[i]));
      check("paren.out_seq",   32'(out),   32'(exp_po[i]));
    end
`else
    send_str(s);
    check("paren_dis.err", 32'(err), 1);
    check("paren_dis.len", 32'(len), 1);
`endif

    // Space inside a number
    do_clr();
    send_str("12 3");
    check("space.err", 32'(err), 1);
    check("space.len", 32'(len), 4);
    check("space.out", 32'(out), 0);
    send_str("+4");
    check("space.err_sticky", 32'(err), 1);
    check("space.len_frozen", 32'(len), 4);

    // Too many digits
    do_clr();
    send_str("1234");
    check("digits4.err", 32'(err), 0);
    send_str("5");
    check("digits5.err", 32'(err), 1);
    check("digits5.len", 32'(len), 5);

    // Nesting overflow
    do_clr();
    send_str("((((((((");
`ifdef EXPR_PAREN_EN
    check("nest.err",   32'(err),   1);
    check("nest.depth", 32'(depth), 7);
    check("nest.len",   32'(len),   8);
`else
    check("nest.err",   32'(err),   1);
    check("nest.depth", 32'(depth), 0);
    check("nest.len",   32'(len),   1);
`endif

    do_clr();
    send_str(")");
    check("rp_first.err", 32'(err), 1);

    do_clr();
    send_str("1+");
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    check("trailing_op.err", 32'(err), 0);
    check("trailing_op.out", 32'(out), 0);

    do_clr();
    send_str("-5");
    check("unary.err", 32'(err), 1);
    check("unary.len", 32'(len), 1);

    // Clear mid-expression, then restart
    do_clr();
    send_str("3*(");
    do_clr();
    send_str("7");
    check("restart.out", 32'(out), 1);
    check("restart.len", 32'(len), 1);

    // Stall inside a number
    do_clr();
    send_str("12");
    for (int i = 0; i < 5; i++) send("9", 1'b0);
    check("stall.out", 32'(out), 1);
    check("stall.len", 32'(len), 2);
    send_str("3 ");
    check("stall.len_after", 32'(len), 4);

    // Leading zeros and a long stream for counter saturation
    do_clr();
    send_str("0007");
    for (int i = 0; i < 150; i++) send_str("/1");
    check("sat.len", 32'(len), LEN_MAX);
    check("sat.err", 32'(err), 0);
    check("sat.out", 32'(out), 1);

    // Randomised streams against the model
    alpha = "0123456789+-*/ ()x";
    for (int r = 0; r < 30; r++) begin
      do_clr();
      for (int k = 0; k < 40; k++) begin
        int  idx;
        byte ch;
        if ($urandom_range(1, 0) == 1) idx = $urandom_range(9, 0);
        else                           idx = $urandom_range(17, 10);
        ch = alpha[idx];
        send(ch, ($urandom_range(3, 0) != 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/expr_checker.md
# expr_checker

Streaming arithmetic-expression validator for the P1 character-recognition family. It extends the single-digit `digit (op digit)*` recogniser in four ways: multi-digit operands, four operators, ignorable spaces and bounded parenthesis nesting. It consumes one ASCII character per valid cycle from an upstream byte source and continuously flags whether the characters accepted so far form a complete expression. It also reports the first error and where it occurred.

## Interface
Parameters:
- MAX_DIGITS, 4, maximum digits per operand (≥1)
- MAX_DEPTH, 7, maximum parenthesis nesting depth (≥1)
- LEN_W, 8, width of character counter

Ports:
- clk  in  1  clock, rising edge
- clr  in  1  reset, asynchronous, active-high
- in_valid  in  1  `in` carries a character this cycle
- in  in  8  ASCII character
- out  out  1  accepted prefix is a complete, balanced expression
- err  out  1  sticky error flag
- depth  out  DW  current open-paren count, DW = $clog2(MAX_DEPTH+1)
- len  out  LEN_W  characters consumed; frozen at offending index on error

## Operation
- Character classes:
  - DIG: '0'..'9'
  - OP: '+', '-', '*', '/'
  - SP: ' ' (0x20)
  - LP: '('
  - RP: ')'
  - Anything else is illegal.
- States:
  - START: expect operand
  - NUM: inside number
  - END: operand complete, digit not allowed
  - OPR: after operator
  - ERR
- START / OPR:
  - DIG → NUM, digit count = 1
  - LP → START with depth+1; if depth == MAX_DEPTH, → ERR
  - SP → stay
  - All else → ERR
- NUM:
  - DIG → NUM, count+1; if count == MAX_DIGITS already, → ERR
  - OP → OPR
  - SP → END
  - RP → END with depth−1; if depth == 0, → ERR
  - All else → ERR
- END:
  - OP → OPR
  - SP → stay
  - RP → END with depth−1; if depth == 0, → ERR
  - All else (including DIG) → ERR
- ERR is absorbing until clr. err = (state == ERR).
- out = (state ∈ {NUM, END}) && depth == 0 && !err.
- len:
  - Increments on every in_valid character processed outside ERR, including the offending character's cycle.
  - In ERR, len is not incremented, so len after error equals offending index + 1.
  - Saturates at 2^LEN_W−1; no wrap.
- in_valid low: all state, counters and outputs hold.
- Leading zeros are legal. There is no unary minus: '-' in START or OPR → ERR.

## Timing
- Fully registered outputs. A character sampled at edge N is reflected in out, err, depth and len after edge N; latency is 1 cycle.
- No backpressure; one character per cycle accepted continuously.
- clr asserted (any time, including mid-expression): immediately forces state START, out 0, err 0, depth 0, len 0, digit count 0. First character is sampled at the first rising edge after clr deasserts.
- Simultaneous events in one character cannot occur. Error checks take priority over depth and count updates: on overflow or underflow, depth and digit count are not modified.

## Configuration
- EXPR_PAREN_EN
- Defined: LP and RP behave as above; depth tracks nesting.
- Undefined: LP and RP are illegal characters (→ ERR); depth is tied to 0; MAX_DEPTH is unused.

## Test plan
- "12+3*45" with in_valid every cycle → out 1 after last edge, err 0, len 7, depth 0; out toggles 1,1,0,1,0,1,1 across the stream.
- "(1+(2))" with EXPR_PAREN_EN → depth sequence 1,1,1,2,2,1,0; out 1 only after final ')'.
- "12 3" → err 1 on the '3' edge, len 4, out 0; further "+4" leaves err 1 and len 4.
- MAX_DIGITS=4, "12345" → err on 5th digit, len 5. MAX_DEPTH=7, eight '(' → err on 8th, depth 7.
- ")" first, "1+" then idle, and "-5" → err 1, err 0 with out 0, and err 1 respectively.
- clr pulsed mid-stream after "3*(" → all outputs 0 in the same cycle; then "7" → out 1, len 1. Stall in_valid low 5 cycles mid-number → outputs unchanged.
